// File: rtl/mux_16_1_arbiter_if.sv
// mux_16_1_arbiter_if: request, data and grant bundle between the requesters and the arbiter.
interface mux_16_1_arbiter_if;
  logic [0:15] req;
  logic [0:15] din;
  logic [0:15] grant;
  logic [0:3] select;
  logic valid;
  logic dout;
  modport master (output req, din, input grant, select, valid, dout);
  modport slave (input req, din, output grant, select, valid, dout);
endinterface

// File: rtl/mux_16_1_arbiter.sv
// mux_16_1_arbiter: round-robin, hold-limited arbiter steering a 16:1 mux to the granted requester.
module mux_16_1 (
  input  logic [0:15] inp,
  input  logic [0:3]  sel,
  output logic        out
);
  assign out = inp[sel];
endmodule

module mux_16_1_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input logic clk,
  input logic reset,
  mux_16_1_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [0:3] ptr, ptr_n, idx, idx_n, cnt, cnt_n, start, win;
  logic found, rel, mux_out;
  always_comb begin
    rel = !bus.req[idx] || cnt == 4'(MAX_HOLD);
    start = (state == GRANT && rel) ? idx + 4'd1 : ptr;
    found = 1'b0;
    win = start;
    // Descending scan so the candidate closest to start wins.
    for (int k = 15; k >= 0; k--)
      if (bus.req[start + 4'(k)]) begin
        found = 1'b1;
        win = start + 4'(k);
      end
    state_n = state;
    ptr_n = ptr;
    idx_n = idx;
    cnt_n = cnt;
    if (state == IDLE) begin
      state_n = found ? GRANT : IDLE;
      idx_n = found ? win : idx;
      cnt_n = found ? 4'd1 : cnt;
    end else if (!rel) begin
      cnt_n = cnt + 4'd1;
    end else begin
      ptr_n = start;
      state_n = found ? GRANT : IDLE;
      idx_n = found ? win : idx;
      cnt_n = found ? 4'd1 : cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      idx <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      idx <= idx_n;
      cnt <= cnt_n;
    end
  end
  assign bus.valid = state == GRANT;
  assign bus.select = idx;
  always_comb begin
    bus.grant = '0;
    for (int i = 0; i < 16; i++) bus.grant[i] = bus.valid && idx == 4'(i);
  end
  mux_16_1 u_mux (.inp(bus.din), .sel(idx), .out(mux_out));
  assign bus.dout = mux_out & bus.valid;
endmodule

// File: tb/tb_mux_16_1_arbiter.sv
// tb_mux_16_1_arbiter: directed vector table, corner sequences and a randomized run against a reference model.
module tb_mux_16_1_arbiter;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  mux_16_1_arbiter_if bus ();
  mux_16_1_arbiter #(.MAX_HOLD(MH)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic [0:15] req;
    logic [0:15] din;
    int g;
    int sel;
    logic dout;
  } vec_t;
  vec_t tbl[$];
  int n_chk = 0;
  int n_fail = 0;
  int mg, mptr, mcnt, msel;
  int wt[16];
  int maxw = 0;
  int hold = 0;
  logic [0:15] q;

  function automatic logic [0:15] rb(input int a, input int b = -1, input int c = -1);
    logic [0:15] r = '0;
    for (int i = 0; i < 16; i++) if (i == a || i == b || i == c) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [0:15] onehot(input int g);
    logic [0:15] r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic check(input string n, input logic [15:0] a, input logic [15:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic add(input logic r, input logic [0:15] rq, input logic [0:15] d, input int g, input int s, input logic o, input int n = 1);
    for (int i = 0; i < n; i++) tbl.push_back('{r, rq, d, g, s, o});
  endtask

  task automatic expect_out(input string n, input int g, input int s, input logic o);
    check({n, " grant"}, 16'(bus.grant), 16'(onehot(g)));
    check({n, " valid"}, 16'(bus.valid), 16'(g >= 0));
    check({n, " select"}, 16'(bus.select), 16'(s));
    check({n, " dout"}, 16'(bus.dout), 16'(o));
  endtask

  // Spec-level arbitration: keep the grant while requested and under the limit, else rotate.
  task automatic model_step(input logic r, input logic [0:15] rq);
    if (r) begin
      mg = -1; mptr = 0; mcnt = 0; msel = 0;
      return;
    end
    if (mg >= 0 && rq[mg] && mcnt < MH) begin
      mcnt++;
      return;
    end
    if (mg >= 0) mptr = (mg + 1) % 16;
    mg = -1;
    for (int k = 0; k < 16; k++)
      if (mg < 0 && rq[(mptr + k) % 16]) begin
        mg = (mptr + k) % 16; mcnt = 1; msel = mg;
      end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    add(1, 16'hffff, 16'h0000, -1, 0, 0, 2);
    add(0, 16'hffff, 16'hffff, 0, 0, 1, 4);
    add(0, 16'hffff, 16'hffff, 1, 1, 1);
    add(0, 16'h0000, 16'hffff, -1, 1, 0);
    add(0, rb(3, 9, 15), 16'hffff, 3, 3, 1, 4);
    add(0, rb(3, 9, 15), 16'hffff, 9, 9, 1, 4);
    add(0, rb(3, 9, 15), 16'hffff, 15, 15, 1, 4);
    add(0, rb(3, 9, 15), 16'hffff, 3, 3, 1);
    add(0, 16'h0000, 16'hffff, -1, 3, 0);
    add(0, rb(7), 16'hffff, 7, 7, 1, 2);
    add(0, 16'h0000, 16'hffff, -1, 7, 0);
    add(0, rb(2), 16'hffff, 2, 2, 1);
    add(0, rb(5), 16'hffff, 5, 5, 1, 8);
    add(0, rb(12), 16'b0000_0000_0000_1000, 12, 12, 1);
    bus.req = '0;
    bus.din = '0;
    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      bus.req = tbl[i].req;
      bus.din = tbl[i].din;
      @(posedge clk);
      #1;
      expect_out($sformatf("row%0d", i), tbl[i].g, tbl[i].sel, tbl[i].dout);
    end
    bus.din[12] = 1'b0;
    #1;
    check("din12 drop dout", 16'(bus.dout), 16'd0);
    bus.din = 16'hffff;
    bus.req = rb(10);
    @(posedge clk);
    #1;
    expect_out("wrap to 10", 10, 10, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    expect_out("mid-grant reset", -1, 0, 0);
    reset = 1'b0;
    bus.req = rb(10, 14);
    @(posedge clk);
    #1;
    expect_out("post-reset ptr0", 10, 10, 1);
    reset = 1'b1;
    @(posedge clk);
    model_step(1'b1, '0);
    #1;
    foreach (wt[i]) wt[i] = 0;
    for (int c = 0; c < 800; c++) begin
      if (hold == 0) begin
        q = 16'($urandom & $urandom & $urandom);
        if ($urandom_range(0, 7) == 0) q = '0;
        hold = $urandom_range(1, 10);
      end
      hold--;
      reset = $urandom_range(0, 99) == 0;
      bus.req = q;
      bus.din = 16'($urandom);
      @(posedge clk);
      model_step(reset, q);
      #1;
      expect_out($sformatf("rand%0d", c), mg, msel, mg >= 0 ? bus.din[msel] : 1'b0);
      for (int i = 0; i < 16; i++) begin
        wt[i] = (q[i] && !bus.grant[i] && !reset) ? wt[i] + 1 : 0;
        if (wt[i] > maxw) maxw = wt[i];
      end
    end
    check("fairness bound", 16'(maxw <= 15 * MH + 1), 16'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_16_1_arbiter.md
# mux_16_1_arbiter

Round-robin arbiter that shares one `mux_16_1` datapath among 16 single-bit requesters. It grants one requester at a time and drives the 4-bit mux select from that grant, so the granted requester's data bit reaches `dout`. Priority rotates so no requester waits more than 15 grants. A hold limit bounds each grant. It sits directly in front of the `mux_16_1` instance it owns.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles one grant may last. Legal range 1..15.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  [0:15]  request lines. `req[i]` is requester i.
- `din`  input  [0:15]  per-requester data bits. Wired to the internal `mux_16_1` `inp`.
- `grant`  output  [0:15]  one-hot grant. All zero when idle.
- `select`  output  [0:3]  index of the granted requester, MSB = `select[0]`. Also drives the mux select.
- `valid`  output  1  high while a grant is active.
- `dout`  output  1  `mux_16_1` output ANDed with `valid`. Combinational from `din`.

## Operation
- State registers:
  - `state`: IDLE or GRANT.
  - `ptr[0:3]`: priority start index.
  - `idx[0:3]`: current grantee; drives `select`.
  - `cnt[0:3]`: cycles granted so far.
- Search rule: the winner is the first i in order ptr, ptr+1, …, ptr+15 (mod 16) with `req[i]`=1.
- IDLE:
  - `valid`=0, `grant`=0, `select` holds its last value.
  - If any `req` is set, load `idx`=winner, set `cnt`=1 and go to GRANT.
- GRANT:
  - `valid`=1, `grant`=one-hot(`idx`), `select`=`idx`.
  - Each edge evaluates a release condition: `req[idx]`=0 OR `cnt`==`MAX_HOLD`.
  - No release: `cnt` increments; `idx`, `grant` and `select` are unchanged.
  - Release: set `ptr`=`idx`+1 (mod 16, so 15 wraps to 0) and rerun the search from the new `ptr` with the current `req`:
    - Winner found: load `idx`=winner and `cnt`=1, and stay in GRANT. The handoff is back-to-back with no idle cycle.
    - No winner: go to IDLE.
  - If the releasing requester is the only one still requesting, it wins again (the search wraps around to it).
- `dout` = `din[select]` AND `valid`. The select ordering matches `mux_16_1`: `select`=0000 picks `din[0]` and 1111 picks `din[15]`.
- Reset:
  - All outputs and state take these values: `state`=IDLE, `ptr`=0, `idx`=0, `cnt`=0, `grant`=0, `select`=0000, `valid`=0, `dout`=0.
  - Reset mid-grant aborts the grant at that edge regardless of `req`.
  - The first arbitration after reset starts its search at index 0.
- `req` changes on non-grantee lines never disturb an active grant.

## Timing
- Request-to-grant latency: 1 cycle. If `req` is first sampled high at edge k, `grant`, `valid` and `select` are valid after edge k.
- Grant release: if the grantee drops `req` before edge k, `grant` changes at edge k (to the next winner or to all zero).
- Maximum grant length: `MAX_HOLD` cycles with `req` held high.
- Worst-case wait for a continuously requesting line: 15 × `MAX_HOLD` cycles plus 1.
- `dout` is combinational, with no added latency relative to `din` once `select` and `valid` are stable.
- Simultaneous events:
  - Reset overrides any release or grant on the same edge.
  - On a release edge, a request newly asserted at that same edge is visible to the search.

## Test plan
- Reset and first grant: assert `reset` for 2 cycles with `req`=all ones, then release it.
  - During reset: `grant`=0, `valid`=0, `select`=0000.
  - First edge after reset: `grant`=1000…0 (requester 0), `select`=0000.
- Single requester, `MAX_HOLD`=4: only `req[5]` held high.
  - `grant[5]` stays high for 4 cycles, then is re-granted back-to-back with `select`=0101 throughout.
  - `cnt` restarts at 1 on each re-grant; `valid` never drops.
- Round-robin rotation: `req[3]`, `req[9]` and `req[15]` held high.
  - Grants cycle 3→9→15→3, each lasting 4 cycles.
  - `select` sequence: 0011, 1001, 1111, 0011. The 15→3 step exercises pointer wrap-around.
- Early release and idle: grant `req[7]`, then drop it after 2 cycles with no other requests.
  - At that edge: `valid`=0, `grant`=0, `select` stays 0111.
  - Re-assert `req[2]`: granted next edge with `select`=0010.
- Data path: grant requester 12 with `din`=0000_0000_0000_1000.
  - `dout`=1; switching `din[12]` to 0 gives `dout`=0 immediately.
  - When idle, `dout`=0 even with `din` all ones.
- Reset mid-grant: assert `reset` in the 2nd cycle of a grant to `req[10]`.
  - Next edge: all outputs at their reset values.
  - After reset is released with `req[10]` still high: granted again; `ptr` restarted at 0.
